// File: rtl/block_fir_pkg.sv
// Shared types and defaults for the block FIR tap accumulator slice.
// State encoding, default widths and the accumulator width helper live here.
package block_fir_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int NUM_TAPS_DEF   = 16;
    localparam int PROD_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF  = 32;

    // Width that holds the sum of num_taps products without internal overflow.
    function automatic int acc_w(input int prod_width, input int num_taps);
        return prod_width + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/block_fir_tap_accum_if.sv
// Product input stream and output sample stream of the tap accumulator.
// The master drives products and y_ready; the slave (the accumulator) drives the rest.
interface block_fir_tap_accum_if #(
    parameter int PROD_WIDTH = 32,
    parameter int OUT_WIDTH  = 32
);
    // Both channels: a beat transfers on a rising edge where valid and ready are
    // both high; the source holds data stable while valid is high and ready is low.
    logic                  prod_valid;
    logic                  prod_ready;
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  y_valid;
    logic                  y_ready;
    logic [OUT_WIDTH-1:0]  y_data;
    logic                  y_ovf;

    modport master (
        output prod_valid, prod_data, y_ready,
        input  prod_ready, y_valid, y_data, y_ovf
    );

    modport slave (
        input  prod_valid, prod_data, y_ready,
        output prod_ready, y_valid, y_data, y_ovf
    );

endinterface

// File: rtl/block_fir_out_sat.sv
// Output shaping: arithmetic shift, signed range check, then clamp or wrap.
// Clamping is selected by defining BLOCK_FIR_ACC_SAT_EN; otherwise the value wraps.
module block_fir_out_sat #(
    parameter int ACC_W     = 36,
    parameter int OUT_WIDTH = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [OUT_WIDTH-1:0]    y_data,
    output logic                    y_ovf
);

    logic signed [ACC_W-1:0] s;

    assign s = acc >>> OUT_SHIFT;

    if (ACC_W > OUT_WIDTH) begin : g_narrow
        // In range exactly when every bit from the output sign bit upward agrees.
        logic [ACC_W-OUT_WIDTH:0] hi;
        assign hi    = s[ACC_W-1:OUT_WIDTH-1];
        assign y_ovf = !((&hi) || !(|hi));
`ifdef BLOCK_FIR_ACC_SAT_EN
        assign y_data = !y_ovf    ? s[OUT_WIDTH-1:0] :
                        s[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                     {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
        assign y_data = s[OUT_WIDTH-1:0];
`endif
    end else begin : g_wide
        assign y_ovf  = 1'b0;
        assign y_data = OUT_WIDTH'(s);
    end

endmodule

// File: rtl/block_fir_tap_accum.sv
// Sums each group of NUM_TAPS signed products into one shifted, range-checked sample.
// Output clamping is enabled by the BLOCK_FIR_ACC_SAT_EN macro (wrap when undefined).
module block_fir_tap_accum
    import block_fir_pkg::*;
#(
    parameter int NUM_TAPS   = NUM_TAPS_DEF,
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    block_fir_tap_accum_if.slave bus,
    output state_t               dbg_state
);

    localparam int ACC_W = acc_w(PROD_WIDTH, NUM_TAPS);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [TAP_W-1:0]        tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;
    logic                    last_tap;
    logic [OUT_WIDTH-1:0]    sat_data;
    logic                    sat_ovf;
    logic [OUT_WIDTH-1:0]    y_data_q;
    logic                    y_ovf_q;

    assign prod_ext = {{(ACC_W-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
    assign acc_sum  = acc + prod_ext;
    assign accept   = bus.prod_valid && bus.prod_ready;
    assign last_tap = (tap == LAST_TAP);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_tap) state_nxt = HOLD;
            HOLD:    if (bus.y_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // In HOLD the sample hand-off and the next frame's tap 0 share one cycle.
    always_comb begin
        bus.prod_ready = 1'b0;
        bus.y_valid    = 1'b0;
        if (!ap_rst) begin
            case (state)
                ACCUM: bus.prod_ready = 1'b1;
                HOLD: begin
                    bus.prod_ready = bus.y_ready;
                    bus.y_valid    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // tap is always 0 in HOLD, so an overlapped accept restarts the sum there.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            tap      <= '0;
            acc      <= '0;
            y_data_q <= '0;
            y_ovf_q  <= 1'b0;
        end else if (accept) begin
            acc <= (tap == '0) ? prod_ext : acc_sum;
            tap <= last_tap ? '0 : tap + 1'b1;
            if (last_tap) begin
                y_data_q <= sat_data;
                y_ovf_q  <= sat_ovf;
            end
        end
    end

    block_fir_out_sat #(
        .ACC_W     (ACC_W),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_out_sat (
        .acc    (acc_sum),
        .y_data (sat_data),
        .y_ovf  (sat_ovf)
    );

    assign bus.y_data = y_data_q;
    assign bus.y_ovf  = y_ovf_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_block_fir_tap_accum.sv
// Bench for block_fir_tap_accum: two instances (OUT_SHIFT 0 and 1) share one stimulus
// stream; a frame-sum reference model feeds an expected queue popped by a monitor.
module tb_block_fir_tap_accum;
    import block_fir_pkg::*;

    localparam int NUM_TAPS = 4;
    localparam longint OMAX = 64'sd2147483647;
    localparam longint OMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] d0;
        logic        o0;
        logic [31:0] d1;
        logic        o1;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        y_ready;
    logic        rand_ready;
    int          cyc;
    int          n_checks;
    int          n_err;
    logic        presenting;
    exp_t        exp_q[$];
    logic [31:0] frame_q[$];
    exp_t        mon_e;
    state_t      st0;
    state_t      st1;

    block_fir_tap_accum_if #(.PROD_WIDTH(32), .OUT_WIDTH(32)) bus0 ();
    block_fir_tap_accum_if #(.PROD_WIDTH(32), .OUT_WIDTH(32)) bus1 ();

    assign bus0.prod_valid = prod_valid;
    assign bus0.prod_data  = prod_data;
    assign bus0.y_ready    = y_ready;
    assign bus1.prod_valid = prod_valid;
    assign bus1.prod_data  = prod_data;
    assign bus1.y_ready    = y_ready;

    block_fir_tap_accum #(.NUM_TAPS(NUM_TAPS), .PROD_WIDTH(32), .OUT_WIDTH(32), .OUT_SHIFT(0)) dut0 (
        .ap_clk    (clk),
        .ap_rst    (rst),
        .bus       (bus0),
        .dbg_state (st0)
    );

    block_fir_tap_accum #(.NUM_TAPS(NUM_TAPS), .PROD_WIDTH(32), .OUT_WIDTH(32), .OUT_SHIFT(1)) dut1 (
        .ap_clk    (clk),
        .ap_rst    (rst),
        .bus       (bus1),
        .dbg_state (st1)
    );

    // clock / reset / cycle count
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: whole-frame sum, shift, signed 32-bit range, clamp or wrap
    task automatic model(input longint sum, input int sh, output logic [31:0] d, output logic o);
        longint s;
        s = sum >>> sh;
        o = (s > OMAX) || (s < OMIN);
`ifdef BLOCK_FIR_ACC_SAT_EN
        if (s > OMAX)      d = 32'h7fffffff;
        else if (s < OMIN) d = 32'h80000000;
        else               d = s[31:0];
`else
        d = s[31:0];
`endif
    endtask

    task automatic note_accept(input logic [31:0] p, input int edge_cyc);
        longint sum;
        exp_t   e;
        frame_q.push_back(p);
        if (frame_q.size() == NUM_TAPS) begin
            sum = 0;
            foreach (frame_q[i]) sum += longint'($signed(frame_q[i]));
            model(sum, 0, e.d0, e.o0);
            model(sum, 1, e.d1, e.o1);
            e.cyc = edge_cyc;
            exp_q.push_back(e);
            frame_q.delete();
        end
    endtask

    // driver tasks: each returns 1 time unit after a rising edge
    task automatic put(input logic [31:0] p);
        int t;
        t = 0;
        prod_valid = 1'b1;
        prod_data  = p;
        @(negedge clk);
        while (!bus0.prod_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus0.prod_ready) begin
            check("accept_timeout", 64'(bus0.prod_ready), 64'd1);
        end else begin
            note_accept(p, cyc + 1);
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_data  = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input int max_gap);
        logic [31:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            put(v[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        prod_valid = 1'b0;
        @(negedge clk);
        check("rst_prod_ready0", 64'(bus0.prod_ready), 64'd0);
        check("rst_prod_ready1", 64'(bus1.prod_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_q.delete();
        exp_q.delete();
        presenting = 1'b0;
        @(negedge clk);
        check("rst_y_valid", 64'(bus0.y_valid), 64'd0);
        check("rst_y_data0", 64'(bus0.y_data), 64'd0);
        check("rst_y_ovf0", 64'(bus0.y_ovf), 64'd0);
        check("rst_y_data1", 64'(bus1.y_data), 64'd0);
        check("rst_state", 64'(st0), 64'(ACCUM));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
            default: return 32'($urandom_range(0, 2000)) - 32'd1000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            y_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (bus0.y_valid || bus1.y_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_y_valid", 64'(bus0.y_valid), 64'd0);
            end else begin
                mon_e = exp_q[0];
                check("y_valid0", 64'(bus0.y_valid), 64'd1);
                check("y_valid1", 64'(bus1.y_valid), 64'd1);
                check("y_data_shift0", 64'(bus0.y_data), 64'(mon_e.d0));
                check("y_ovf_shift0", 64'(bus0.y_ovf), 64'(mon_e.o0));
                check("y_data_shift1", 64'(bus1.y_data), 64'(mon_e.d1));
                check("y_ovf_shift1", 64'(bus1.y_ovf), 64'(mon_e.o1));
                if (!presenting) begin
                    check("latency", 64'(cyc), 64'(mon_e.cyc));
                    presenting = 1'b1;
                end
                if (!y_ready) begin
                    check("hold_prod_ready", 64'(bus0.prod_ready), 64'd0);
                end else begin
                    check("overlap_prod_ready", 64'(bus0.prod_ready), 64'd1);
                    void'(exp_q.pop_front());
                    presenting = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        n_checks   = 0;
        n_err      = 0;
        cyc        = 0;
        presenting = 1'b0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        y_ready    = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // basic frame, overflow, negative sum, all back-to-back
        send4(32'd1, 32'd2, 32'd3, 32'd4, 0);
        send4(32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 0);
        send4(-32'sd5, -32'sd5, -32'sd5, -32'sd5, 0);
        idle(3);

        // backpressure: result held 5 cycles while the next frame waits
        y_ready = 1'b0;
        send4(32'd11, 32'd22, 32'd33, 32'd44, 0);
        fork
            send4(-32'sd100, 32'd50, 32'd7, 32'd1, 0);
            begin
                idle(5);
                y_ready = 1'b1;
            end
        join
        idle(3);

        // reset in the middle of a frame
        put(32'd100);
        put(32'd200);
        do_reset();
        send4(32'd7, 32'd7, 32'd7, 32'd7, 0);
        idle(2);

        // bubbles inside a frame
        send4(32'd10, -32'sd3, 32'd6, 32'd1, 3);
        idle(2);

        // randomized frames with random gaps and random consumer stalls
        rand_ready = 1'b1;
        repeat (30) send4(rnd(), rnd(), rnd(), rnd(), ($urandom_range(0, 1) != 0) ? 2 : 0);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        y_ready = 1'b1;

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        check("final_state", 64'(st0), 64'(ACCUM));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/block_fir_tap_accum.md
# block_fir_tap_accum

Downstream stage of the block FIR multiplier. It takes the stream of signed 32-bit tap products, one per accepted beat, and sums each group of NUM_TAPS products into one output sample. It then applies an arithmetic output shift and range-checks the result, and presents the sample on a valid/ready port to the block FIR output interface.

## Interface
- NUM_TAPS, 16: products per output sample; legal range 2..1024.
- PROD_WIDTH, 32: product width, signed.
- OUT_WIDTH, 32: output sample width, signed.
- OUT_SHIFT, 0: arithmetic right shift applied to the sum before the range check; range 0..31.
- ap_clk  in  1  the only clock; everything is on its rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- prod_valid  in  1  prod_data holds a valid product.
- prod_ready  out  1  block accepts a product this cycle.
- prod_data  in  PROD_WIDTH  signed tap product.
- y_valid  out  1  y_data holds a finished output sample.
- y_ready  in  1  consumer takes the sample this cycle.
- y_data  out  OUT_WIDTH  finished output sample.
- y_ovf  out  1  the shifted sum was outside the signed OUT_WIDTH range; valid together with y_data.

## Operation
- Accumulator width: ACC_W = PROD_WIDTH + clog2(NUM_TAPS). The accumulator never overflows internally.
- Each product is sign-extended to ACC_W before it is added.
- Tap counter `tap` runs 0..NUM_TAPS-1.
- A product is accepted when prod_valid and prod_ready are both high.
- States and transitions:
  - ACCUM: prod_ready=1, y_valid=0.
    - Accept with tap==0: acc <= product.
    - Accept with tap>0: acc <= acc + product.
    - Every accept: tap increments.
    - Accept with tap==NUM_TAPS-1: tap <= 0, state goes to HOLD, and y_data/y_ovf are registered from the final sum.
  - HOLD: y_valid=1, and prod_ready is driven combinationally equal to y_ready.
    - y_ready=1 with prod_valid=1: the sample is handed off and the product is accepted as tap 0 of the next frame in the same cycle (acc <= product, tap <= 1, state goes to ACCUM).
    - y_ready=1 with prod_valid=0: state goes to ACCUM, tap stays 0.
    - y_ready=0: y_data and y_ovf hold stable; no product is accepted.
- Output path: s = acc >>> OUT_SHIFT (arithmetic shift).
  - y_ovf = 1 when s > 2^(OUT_WIDTH-1)-1 or s < -2^(OUT_WIDTH-1).
  - y_data is selected by the configuration macro below.
- prod_valid gaps anywhere in a frame do not change the result.

## Timing
- Reset values: state ACCUM, tap 0, acc 0, y_valid 0, y_data 0, y_ovf 0.
- prod_ready is forced to 0 during any cycle in which ap_rst is high.
- Reset mid-frame discards the partial sum. The first product accepted after reset is tap 0.
- Latency: y_valid rises on the cycle after the last product of a frame is accepted.
- Throughput: NUM_TAPS cycles per sample when y_ready is held at 1 and prod_valid is continuous. The HOLD-to-ACCUM overlap leaves no bubble.
- prod_ready and y_valid never depend combinationally on prod_valid.

## Configuration
- BLOCK_FIR_ACC_SAT_EN defined: y_data is clamped.
  - s above range gives 2^(OUT_WIDTH-1)-1.
  - s below range gives -2^(OUT_WIDTH-1).
- BLOCK_FIR_ACC_SAT_EN undefined: y_data = s[OUT_WIDTH-1:0] (two's-complement wrap).
- y_ovf behaves identically in both builds.

## Structure
- Package block_fir_pkg holds:
  - the state enum (ACCUM, HOLD);
  - the default NUM_TAPS, PROD_WIDTH and OUT_WIDTH constants;
  - an ACC_W helper function.
- One sub-module, block_fir_out_sat:
  - combinational shift, range check and clamp/wrap;
  - parameters ACC_W, OUT_WIDTH, OUT_SHIFT;
  - contains the only BLOCK_FIR_ACC_SAT_EN conditional.
- The top level holds the FSM, the tap counter, the accumulator and the output registers.

## Test plan
All scenarios use NUM_TAPS=4, PROD_WIDTH=OUT_WIDTH=32.
- Basic frame: products 1, 2, 3, 4 back-to-back, y_ready=1, OUT_SHIFT=0.
  - y_valid=1 on the cycle after the 4th accept.
  - y_data=10, y_ovf=0.
- Positive overflow: four products of 0x7FFFFFFF.
  - SAT_EN build: y_data=0x7FFFFFFF, y_ovf=1.
  - Wrap build: y_data=0xFFFFFFFC, y_ovf=1.
- Negative sum with shift: four products of -5 with OUT_SHIFT=1.
  - y_data=0xFFFFFFF6 (-10), y_ovf=0.
- Backpressure: y_ready=0 for 5 cycles after a result while the next frame is offered with prod_valid=1.
  - prod_ready=0 and y_data stable for all 5 cycles.
  - When y_ready rises, the next frame's first product is accepted in that same cycle.
  - The next sum is correct.
- Reset mid-frame: accept 100 and 200, then pulse ap_rst for 1 cycle, then send 7, 7, 7, 7.
  - y_data=28.
  - All outputs are at their reset values during the reset cycle.
- Bubbles: frame 10, -3, 6, 1 with random prod_valid gaps of 0..3 cycles.
  - y_data=14, and it appears exactly one cycle after the 4th accept.
